// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into PRESS/LONG/REPEAT/RELEASE
// events, arbitrated round-robin into a small FIFO drained over valid/ready.
module button_event_ctrl #(
  parameter int NBTN          = 4,
  parameter int IDXW          = 2,
  parameter int CW            = 24,
  parameter int LONG_CYCLES   = 13500000,
  parameter int REPEAT_CYCLES = 2700000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NBTN-1:0] clean,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDXW-1:0] evt_btn,
  output logic [1:0]      evt_type,
  output logic            overflow,
  input  logic            clear_ovf
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OCW = PW + 1;
  localparam int EW  = IDXW + 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_LONG    = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

  localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0]  REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [OCW-1:0] DEPTH_C   = OCW'(FIFO_DEPTH);

  logic [1:0]      state_q [NBTN];
  logic [1:0]      state_d [NBTN];
  logic [CW-1:0]   cnt_q   [NBTN];
  logic [CW-1:0]   cnt_d   [NBTN];
  logic [NBTN-1:0] prev_q, prev_d;
  logic [NBTN-1:0] raise_s;
  logic [1:0]      raise_type_s [NBTN];

  logic [NBTN-1:0] pend_v_q, pend_v_d;
  logic [1:0]      pend_t_q [NBTN];
  logic [1:0]      pend_t_d [NBTN];
  logic [NBTN-1:0] gnt_s;
  logic [NBTN-1:0] drop_s;
  logic            ovf_q, ovf_d;

  logic            fifo_full_s;
  logic            grant_s;
  logic            pick_s;
  logic [IDXW-1:0] cand_s;
  logic [IDXW-1:0] grant_idx_s;
  logic [IDXW-1:0] rr_q, rr_d;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [OCW-1:0]  occ_q, occ_d;
  logic            push_s, pop_s;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] btn_q, btn_d;
  logic [1:0]      type_q, type_d;

  // Per-button hold FSM: rising-edge detect, hold counter, event raise.
  always_comb begin
    prev_d = clean;
    for (int i = 0; i < NBTN; i++) begin
      state_d[i]      = state_q[i];
      cnt_d[i]        = cnt_q[i];
      raise_s[i]      = 1'b0;
      raise_type_s[i] = EV_PRESS;
      case (state_q[i])
        ST_IDLE: begin
          if (clean[i] && !prev_q[i]) begin
            state_d[i]      = ST_PRESSED;
            cnt_d[i]        = '0;
            raise_s[i]      = 1'b1;
            raise_type_s[i] = EV_PRESS;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (!clean[i]) begin
            state_d[i]      = ST_IDLE;
            cnt_d[i]        = '0;
            raise_s[i]      = 1'b1;
            raise_type_s[i] = EV_RELEASE;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i]      = ST_HELD;
            cnt_d[i]        = '0;
            raise_s[i]      = 1'b1;
            raise_type_s[i] = EV_LONG;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_HELD: begin
          if (!clean[i]) begin
            state_d[i]      = ST_IDLE;
            cnt_d[i]        = '0;
            raise_s[i]      = 1'b1;
            raise_type_s[i] = EV_RELEASE;
          end else if ((REPEAT_CYCLES != 0) && (cnt_q[i] == REP_LAST)) begin
            cnt_d[i]        = '0;
            raise_s[i]      = 1'b1;
            raise_type_s[i] = EV_REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Round-robin arbiter: first pending slot at or after rr, only if FIFO has room.
  always_comb begin
    fifo_full_s = (occ_q == DEPTH_C);
    grant_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    pick_s      = 1'b0;
    if (!fifo_full_s) begin
      for (int k = 0; k < NBTN; k++) begin
        cand_s      = IDXW'((int'(rr_q) + k) % NBTN);
        pick_s      = pend_v_q[cand_s] && !grant_s;
        grant_idx_s = pick_s ? cand_s : grant_idx_s;
        grant_s     = grant_s | pick_s;
      end
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      rr_d = IDXW'((int'(grant_idx_s) + 1) % NBTN);
    end else begin
      rr_d = rr_q;
    end
  end

  // Pending slots: a slot being granted this edge can accept a new event.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      gnt_s[i]    = grant_s && (grant_idx_s == IDXW'(i));
      pend_v_d[i] = pend_v_q[i];
      pend_t_d[i] = pend_t_q[i];
      drop_s[i]   = 1'b0;
      if (raise_s[i]) begin
        if (!pend_v_q[i] || gnt_s[i]) begin
          pend_v_d[i] = 1'b1;
          pend_t_d[i] = raise_type_s[i];
        end else begin
          drop_s[i] = 1'b1;
        end
      end else if (gnt_s[i]) begin
        pend_v_d[i] = 1'b0;
      end else begin
        pend_v_d[i] = pend_v_q[i];
      end
    end
    if (|drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Event FIFO; the head is re-registered from the post-update storage.
  always_comb begin
    push_s = grant_s;
    pop_s  = valid_q && evt_ready;
    mem_d  = mem_q;
    if (push_s) begin
      mem_d[wr_q] = {grant_idx_s, pend_t_q[grant_idx_s]};
    end else begin
      mem_d[wr_q] = mem_q[wr_q];
    end
    rd_d = pop_s  ? rd_q + PW'(1) : rd_q;
    wr_d = push_s ? wr_q + PW'(1) : wr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCW'(1);
      2'b01:   occ_d = occ_q - OCW'(1);
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != '0);
    if (valid_d) begin
      btn_d  = mem_d[rd_d][EW-1:2];
      type_d = mem_d[rd_d][1:0];
    end else begin
      btn_d  = btn_q;
      type_d = type_q;
    end
  end

  // Per-button FSM, edge-detect and pending-slot state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i]  <= ST_IDLE;
        cnt_q[i]    <= '0;
        pend_t_q[i] <= EV_PRESS;
      end
      prev_q   <= '0;
      pend_v_q <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        pend_t_q[i] <= pend_t_d[i];
      end
      prev_q   <= prev_d;
      pend_v_q <= pend_v_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage, pointers and registered head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem_q[d] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
      btn_q   <= '0;
      type_q  <= EV_PRESS;
    end else begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem_q[d] <= mem_d[d];
      end
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      type_q  <= type_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_btn   = btn_q;
  assign evt_type  = type_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: vector table, directed hold/overflow/reset cases,
// and random stimulus against a queue-based event model.
module tb_button_event_ctrl;

  localparam int NBTN = 4, IDXW = 2, CW = 8, LONG = 8, REP = 4, DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] clean = 4'b0000;
  logic       evt_ready = 1'b1;
  logic       clear_ovf = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  button_event_ctrl #(
    .NBTN(NBTN), .IDXW(IDXW), .CW(CW), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .clean(clean), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_btn(evt_btn), .evt_type(evt_type),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clock = ~clock;

  // Reference model: hold time measured from the press edge, events as a queue.
  bit         m_pressed [4];
  int         m_tp [4];
  bit         m_prev [4];
  bit         m_pv [4];
  logic [1:0] m_pt [4];
  logic [3:0] m_q [$];
  int         m_rr;
  bit         m_ovf;
  int         m_now;
  logic [3:0] m_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pressed[i] = 0; m_tp[i] = 0; m_prev[i] = 0; m_pv[i] = 0; m_pt[i] = 2'd0;
    end
    m_q.delete();
    m_rr = 0; m_ovf = 0; m_now = 0; m_head = 4'h0;
  endtask

  task automatic model_edge();
    bit         rs [4];
    logic [1:0] rt [4];
    int         g;
    int         d;
    bit         drop;
    g = -1;
    drop = 0;
    for (int i = 0; i < 4; i++) begin
      rs[i] = 0; rt[i] = 2'd0;
      if (!m_pressed[i]) begin
        if (clean[i] && !m_prev[i]) begin
          m_pressed[i] = 1; m_tp[i] = m_now; rs[i] = 1; rt[i] = 2'd0;
        end
      end else if (!clean[i]) begin
        m_pressed[i] = 0; rs[i] = 1; rt[i] = 2'd3;
      end else begin
        d = m_now - m_tp[i];
        if (d == LONG) begin
          rs[i] = 1; rt[i] = 2'd1;
        end else if (d > LONG && REP != 0 && ((d - LONG) % REP) == 0) begin
          rs[i] = 1; rt[i] = 2'd2;
        end
      end
    end
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && m_pv[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
    end
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({2'(g), m_pt[g]});
      m_rr = (g + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      if (rs[i]) begin
        if (!m_pv[i] || g == i) begin
          m_pv[i] = 1; m_pt[i] = rt[i];
        end else begin
          drop = 1;
        end
      end else if (g == i) begin
        m_pv[i] = 0;
      end
      m_prev[i] = clean[i];
    end
    if (drop) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    m_now++;
    if (m_q.size() > 0) m_head = m_q[0];
  endtask

  task automatic check_model(input string name);
    check(name, {26'd0, evt_valid, evt_btn, evt_type, overflow},
          {26'd0, (m_q.size() > 0), m_head, m_ovf});
  endtask

  // Drive one cycle of inputs after the falling edge, step the model on the rising edge.
  task automatic cycle(input logic [3:0] c, input logic r, input logic clr);
    clean = c; evt_ready = r; clear_ovf = clr;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input logic [3:0] c);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, evt_valid}, 32'd0);
    check("async_rst_ovf", {31'd0, overflow}, 32'd0);
    model_reset();
    clean = c; evt_ready = 1'b1; clear_ovf = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] c;
    logic       ev;
    logic [1:0] eb;
    logic [1:0] et;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic rst, logic [3:0] c, logic ev, logic [1:0] eb, logic [1:0] et);
    vec_t v;
    v.rst = rst; v.c = c; v.ev = ev; v.eb = eb; v.et = et;
    return v;
  endfunction

  initial begin
    // Tap btn2 for three cycles: PRESS then RELEASE, no LONG.
    vecs.push_back(mk(1, 4'b0100, 0, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b0100, 1, 2'd2, 2'd0));
    vecs.push_back(mk(0, 4'b0100, 0, 2'd2, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd2, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 2'd3));
    // btn0/btn3 together with rr=0, then again with rr=1.
    vecs.push_back(mk(1, 4'b1001, 0, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b1001, 1, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b1001, 1, 2'd3, 2'd0));
    vecs.push_back(mk(0, 4'b1001, 0, 2'd3, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd0, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd3, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 2'd3));
    vecs.push_back(mk(0, 4'b0001, 0, 2'd3, 2'd3));
    vecs.push_back(mk(0, 4'b0001, 1, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd0, 2'd3));
    vecs.push_back(mk(0, 4'b1001, 0, 2'd0, 2'd3));
    vecs.push_back(mk(0, 4'b1001, 1, 2'd3, 2'd0));
    vecs.push_back(mk(0, 4'b1001, 1, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd3, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd0, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 2'd3));

    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", {26'd0, evt_valid, evt_btn, evt_type, overflow}, 32'd0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset(4'b0000);
      cycle(vecs[k].c, 1'b1, 1'b0);
      check($sformatf("vec%0d", k), {26'd0, evt_valid, evt_btn, evt_type, overflow},
            {26'd0, vecs[k].ev, vecs[k].eb, vecs[k].et, 1'b0});
    end

    begin : hold_btn1
      int t_press, t_long, t_rel, t_rep1, n_rep, n_other;
      t_press = -1; t_long = -1; t_rel = -1; t_rep1 = -1; n_rep = 0; n_other = 0;
      do_reset(4'b0000);
      for (int k = 0; k < 28; k++) begin
        cycle((k <= 20) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
        check_model("hold_model");
        if (evt_valid) begin
          if (evt_btn != 2'd1) n_other++;
          case (evt_type)
            2'd0: t_press = k;
            2'd1: t_long = k;
            2'd2: begin
              if (n_rep == 0) t_rep1 = k;
              n_rep++;
            end
            default: t_rel = k;
          endcase
        end
      end
      check("hold_press_time", t_press, 1);
      check("hold_long_after_press", t_long - t_press, 8);
      check("hold_first_repeat", t_rep1 - t_long, 4);
      check("hold_repeat_count", n_rep, 3);
      check("hold_release_time", t_rel, 22);
      check("hold_other_btn", n_other, 0);
      check("hold_ovf", {31'd0, overflow}, 32'd0);
    end

    begin : release_on_threshold
      int n_long, t_rel;
      n_long = 0; t_rel = -1;
      do_reset(4'b0000);
      for (int k = 0; k < 13; k++) begin
        cycle((k <= 7) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
        check_model("thr_model");
        if (evt_valid && evt_type == 2'd1) n_long++;
        if (evt_valid && evt_type == 2'd3) t_rel = k;
      end
      check("thr_no_long", n_long, 0);
      check("thr_release_time", t_rel, 9);
    end

    begin : overflow_drain
      logic [3:0] got [$];
      logic [3:0] exp_drain [8];
      logic [3:0] pat [8];
      exp_drain = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h3, 4'h7, 4'h8, 4'hC};
      pat = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
      do_reset(4'b0000);
      for (int k = 0; k < 12; k++) begin
        cycle((k < 8) ? pat[k] : 4'h0, 1'b0, 1'b0);
        check_model("ovf_model");
      end
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_full_head", {28'd0, evt_valid, evt_btn, evt_type[0]}, 32'h8);
      cycle(4'h0, 1'b0, 1'b1);
      check("ovf_cleared", {31'd0, overflow}, 32'd0);
      for (int k = 0; k < 12; k++) begin
        if (evt_valid) got.push_back({evt_btn, evt_type});
        cycle(4'h0, 1'b1, 1'b0);
        check_model("drain_model");
      end
      check("drain_count", got.size(), 8);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("drain%0d", k), (k < got.size()) ? {28'd0, got[k]} : 32'hFFFF,
              {28'd0, exp_drain[k]});
      end
    end

    begin : reset_with_queue
      int n_ev;
      logic [3:0] first;
      n_ev = 0; first = 4'hF;
      do_reset(4'b0000);
      for (int k = 0; k < 4; k++) cycle(4'b0111, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0111, 1'b0, 1'b0);
      check_model("rq_model");
      check("rq_pre_valid", {31'd0, evt_valid}, 32'd1);
      check("rq_pre_ovf", {31'd0, overflow}, 32'd1);
      do_reset(4'b1000);
      for (int k = 0; k < 8; k++) begin
        cycle(4'b1000, 1'b1, 1'b0);
        check_model("rq_post_model");
        if (evt_valid) begin
          if (n_ev == 0) first = {evt_btn, evt_type};
          n_ev++;
        end
      end
      check("rq_post_events", n_ev, 1);
      check("rq_post_first", {28'd0, first}, 32'hC);
    end

    begin : random_run
      logic [3:0] cur;
      logic       rdy, clr;
      cur = 4'b0000;
      do_reset(4'b0000);
      for (int n = 0; n < 3000; n++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 15) == 0) cur[b] = ~cur[b];
        end
        if (((n / 200) % 3) == 2) rdy = ($urandom_range(0, 7) == 0);
        else rdy = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 40) == 0);
        cycle(cur, rdy, clr);
        check_model("rand_model");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
